regfile_write_arbiter: RTL and testbench

//  Owns the single write port of the 32x32 register file. After reset, sweeps all

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request/grant bus between the ALU/LSU writeback paths, the
// register-file write port and the arbiter that owns it.
interface regfile_write_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            rf_regWrite;
  logic [AW-1:0]   rf_A3;
  logic [XLEN-1:0] rf_WD;
  logic            init_done;

  // Requester/observer side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_regWrite, rf_A3, rf_WD, init_done
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rf_regWrite, rf_A3, rf_WD, init_done
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-sweeps all registers after reset,
// then grants one ALU/LSU writeback per cycle (LSU first, ALU anti-starvation).
module regfile_write_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic alu_force;
  logic alu_go;
  logic lsu_go;

  // Grant decision: LSU wins unless the ALU has waited STARVE_MAX cycles.
  always_comb begin
    alu_force = (starve_q == SW'(STARVE_MAX));
    alu_go    = 1'b0;
    lsu_go    = 1'b0;
    if (state_q == RUN) begin
      if (bus.alu_valid && (!bus.lsu_valid || alu_force)) begin
        alu_go = 1'b1;
      end else if (bus.lsu_valid) begin
        lsu_go = 1'b1;
      end
    end
  end

  assign bus.alu_ready   = alu_go;
  assign bus.lsu_ready   = lsu_go;
  assign bus.rf_regWrite = we_q;
  assign bus.rf_A3       = a3_q;
  assign bus.rf_WD       = wd_q;
  assign bus.init_done   = (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    starve_d  = starve_q;
    we_d      = 1'b0;
    a3_d      = a3_q;
    wd_d      = wd_q;

    if (state_q == CLEAR) begin
      we_d      = 1'b1;
      a3_d      = clr_idx_q;
      wd_d      = '0;
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(NREGS - 1)) begin
        state_d   = RUN;
        clr_idx_d = '0;
      end
    end else begin
      // A grant to x0 consumes the request but suppresses the write strobe.
      if (alu_go) begin
        we_d = |bus.alu_rd;
        a3_d = bus.alu_rd;
        wd_d = bus.alu_data;
      end else if (lsu_go) begin
        we_d = |bus.lsu_rd;
        a3_d = bus.lsu_rd;
        wd_d = bus.lsu_data;
      end

      if (bus.alu_valid && !alu_go) begin
        starve_d = alu_force ? starve_q : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      starve_q  <= '0;
      we_q      <= 1'b0;
      a3_q      <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      starve_q  <= starve_d;
      we_q      <= we_d;
      a3_q      <= a3_d;
      wd_q      <= wd_d;
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!reset)
    !(bus.alu_ready && bus.lsu_ready));

  a_no_x0_in_run: assert property (@(posedge clk) disable iff (!reset)
    (state_q == RUN && we_q) |-> (a3_q != '0));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a request/grant model
// and a shadow register file built from the observed write port.
module tb_regfile_write_arbiter;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus();

  regfile_write_arbiter #(
    .XLEN(XLEN), .NREGS(NREGS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  // Shadow register file fed only by the DUT write port.
  logic [XLEN-1:0] rf [NREGS];
  always @(posedge clk) if (bus.rf_regWrite === 1'b1) rf[bus.rf_A3] <= bus.rf_WD;

  // Reference model state
  bit              m_run;
  int unsigned     m_clr, m_streak;
  bit              exp_we, exp_known, exp_init;
  logic [AW-1:0]   exp_a3;
  logic [XLEN-1:0] exp_wd;
  logic [XLEN-1:0] mem [NREGS];

  // Pending requests (held stable until granted)
  bit              a_v, l_v;
  logic [AW-1:0]   a_rd, l_rd;
  logic [XLEN-1:0] a_d, l_d;
  bit              g_alu, g_lsu;

  task automatic model_reset();
    m_run = 0; m_clr = 0; m_streak = 0;
    exp_we = 0; exp_known = 1; exp_init = 0; exp_a3 = '0; exp_wd = '0;
    a_v = 0; l_v = 0; a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;
  endtask

  task automatic commit(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    if (rd != '0) begin
      exp_we = 1; exp_a3 = rd; exp_wd = d; exp_known = 1; mem[rd] = d;
    end else begin
      exp_known = 0;
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step();
    bus.alu_valid = a_v; bus.alu_rd = a_rd; bus.alu_data = a_d;
    bus.lsu_valid = l_v; bus.lsu_rd = l_rd; bus.lsu_data = l_d;
    #1;
    g_alu = 0; g_lsu = 0;
    if (m_run) begin
      if (a_v && (!l_v || m_streak == STARVE_MAX)) g_alu = 1;
      else if (l_v) g_lsu = 1;
    end
    check("alu_ready", bus.alu_ready, g_alu);
    check("lsu_ready", bus.lsu_ready, g_lsu);
    @(posedge clk);
    if (!m_run) begin
      exp_we = 1; exp_a3 = AW'(m_clr); exp_wd = '0; exp_known = 1;
      mem[m_clr] = '0;
      if (m_clr == NREGS - 1) begin m_run = 1; exp_init = 1; end
      m_clr++;
    end else begin
      exp_we = 0;
      if (g_alu) commit(a_rd, a_d);
      else if (g_lsu) commit(l_rd, l_d);
      if (a_v && !g_alu) m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
      else m_streak = 0;
      if (g_alu) a_v = 0;
      if (g_lsu) l_v = 0;
    end
    @(negedge clk);
    check("regWrite", bus.rf_regWrite, exp_we);
    check("init_done", bus.init_done, exp_init);
    if (exp_known) begin
      check("A3", bus.rf_A3, exp_a3);
      check("WD", bus.rf_WD, exp_wd);
    end
  endtask

  task automatic random_requests(input int unsigned pct);
    if (!a_v && $urandom_range(0, 99) < pct) begin
      a_v = 1; a_rd = AW'($urandom_range(0, NREGS - 1)); a_d = $urandom;
    end
    if (!l_v && $urandom_range(0, 99) < pct) begin
      l_v = 1; l_rd = AW'($urandom_range(0, NREGS - 1)); l_d = $urandom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    bus.rf_regWrite, 0);
    check({tag, "_a3"},    bus.rf_A3, 0);
    check({tag, "_wd"},    bus.rf_WD, 0);
    check({tag, "_init"},  bus.init_done, 0);
    check({tag, "_aready"}, bus.alu_ready, 0);
    check({tag, "_lready"}, bus.lsu_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned guard;
    model_reset();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;

    // Held in reset
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Sweep with no requests
    for (int i = 0; i < 32; i++) begin
      step();
      check("sweep_a3", bus.rf_A3, i);
      check("sweep_init", bus.init_done, (i == 31));
    end
    step();
    check("post_sweep_we", bus.rf_regWrite, 0);

    // Lone LSU write
    l_v = 1; l_rd = 5; l_d = 32'hDEADBEEF;
    step();
    check("lsu5_we", bus.rf_regWrite, 1);
    check("lsu5_a3", bus.rf_A3, 5);
    check("lsu5_wd", bus.rf_WD, 32'hDEADBEEF);

    // Both valid every cycle: four LSU grants, then one forced ALU grant
    for (int i = 0; i < 6; i++) begin
      if (!a_v) begin a_v = 1; a_rd = 3; a_d = 32'hA000 + i; end
      if (!l_v) begin l_v = 1; l_rd = 4; l_d = 32'hB000 + i; end
      step();
      check("starve_alu_grant", g_alu, (i == 4));
      if (i == 4) check("starve_a3", bus.rf_A3, 3);
    end
    a_v = 0; l_v = 0;
    step();

    // ALU write to x0: consumed, no strobe
    a_v = 1; a_rd = 0; a_d = 32'h1234;
    step();
    check("x0_grant", g_alu, 1);
    check("x0_we", bus.rf_regWrite, 0);

    // Same destination from both sources: LSU lands first, ALU last
    a_v = 1; a_rd = 7; a_d = 32'h1;
    l_v = 1; l_rd = 7; l_d = 32'h2;
    step();
    check("rd7_first_wd", bus.rf_WD, 32'h2);
    guard = 0;
    while (a_v && guard < 10) begin step(); guard++; end
    check("rd7_alu_served", a_v, 0);
    check("rd7_second_wd", bus.rf_WD, 32'h1);
    repeat (2) step();
    check("rd7_final", rf[7], 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      random_requests(60);
      step();
    end

    // Reset mid-run with requests pending
    random_requests(100);
    bus.alu_valid = 1; bus.lsu_valid = 1;
    bus.alu_rd = 5'd9; bus.lsu_rd = 5'd10;
    #3 reset = 1'b0;
    #1 check_reset_outputs("run_rst");
    @(negedge clk);
    model_reset();
    reset = 1'b1;

    // Reset at clr_idx 10, requests waiting during the restarted sweep
    repeat (10) step();
    check("clr10_a3", bus.rf_A3, 9);
    #3 reset = 1'b0;
    #1 check_reset_outputs("clr_rst");
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      random_requests(80);
      step();
      if (i == 0) check("restart_a3", bus.rf_A3, 0);
    end
    for (int i = 0; i < 200; i++) begin
      random_requests(50);
      step();
    end

    // Drain and compare register-file contents
    a_v = 0; l_v = 0;
    guard = 0;
    repeat (3) step();
    for (int i = 0; i < NREGS; i++) check($sformatf("rf_x%0d", i), rf[i], mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
